seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
- Downstream consumer of the BCD-to-7-segment decoder (four digit patterns D1..D4).
- Time-multiplexes the four patterns onto one shared segment bus plus four anode enables for a common-anode 4-digit display.
- Contains:
  - a refresh prescaler;
  - a digit index counter;
  - a per-frame snapshot register, so a digit never tears mid-frame;
  - an anode guard interval against ghosting.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; legal range REFRESH_DIV >= GUARD+2.
GUARD, 4, cycles at the start of each slot with all anodes off; legal range GUARD >= 0.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  scan enable
- D1  input  [0:6]  units digit pattern, active-low, index 0 = segment a .. 6 = segment g
- D2  input  [0:6]  tens digit pattern
- D3  input  [0:6]  hundreds digit pattern
- D4  input  [0:6]  thousands digit pattern
- seg  output  [0:6]  shared segment bus, active-low
- an  output  [3:0]  anode enables, active-low; an[0] = D1 (rightmost)
- frame_start  output  1  one-cycle pulse when a new snapshot takes effect

Behaviour:
Design has one clock (clk) and a synchronous active-high reset (rst).

Reset:
- seg=1111111, an=1111, frame_start=0.
- cnt=0, idx=0, snapshot all 1111111, load_pending=1.

Counters:
- cnt is $clog2(REFRESH_DIV) bits wide and counts 0..REFRESH_DIV-1 while en=1.
- tick = en && cnt==REFRESH_DIV-1.
- On tick: cnt<=0 and idx<=idx+1 mod 4 (wraps 3->0).
- en=0: cnt and idx hold.

Snapshot load (snap[0..3] <= D1..D4):
- Occurs in the first cycle with en=1 while load_pending=1; load_pending then clears.
- Also occurs on tick with idx==3.
- frame_start=1 in the cycle following any load.
- D inputs are otherwise ignored.

Outputs are registered; values at cycle t+1 are a function of state at cycle t:
- en=0: an=1111, seg=1111111.
- en=1 and cnt<GUARD: an=1111; seg=snap[idx].
- en=1 and cnt>=GUARD: an = onehot-low(idx), i.e. idx0 -> 1110, idx1 -> 1101, idx2 -> 1011, idx3 -> 0111; seg=snap[idx].

Boundaries:
- rst has priority over en and tick.
- Reset mid-frame blanks outputs on the next cycle and re-arms load_pending.
- Dropping and restoring en resumes the same idx/cnt.
- With GUARD=0 the guard interval is absent.
- D changes between loads are never visible on seg.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - At each snapshot load, compute mask[3:1]: digit k (k = 2..4) is blanked iff its pattern equals SEG_ZERO (0000001) and every more-significant digit is also blanked.
  - D1 is never blanked.
  - A blanked slot drives an=1111 and seg=1111111 for the whole slot.
  - The mask resets to 000.
- Undefined: no mask logic; all four digits are always shown.

Decomposition:
- Package seg7_pkg holds:
  - typedef seg_t = logic [0:6];
  - typedef dig_idx_t = logic [1:0];
  - constants SEG_BLANK=7'b1111111, SEG_ZERO=7'b0000001, AN_OFF=4'b1111;
  - function onehot_low(dig_idx_t) returning [3:0].
- Sub-module seg7_prescaler: parameter DIV; ports clk, rst, en; outputs cnt and tick.

Test Plan (REFRESH_DIV=8, GUARD=2):
1. rst=1 for 3 cycles, D*=random -> seg=1111111, an=1111, frame_start=0 every cycle; no X.
2. rst=0, en=1, D1=0000001, D2=1001111, D3=0010010, D4=0000110 ->
   - frame_start pulses once;
   - each 8-cycle slot shows an=1111 for 2 cycles, then 6 cycles of the active anode;
   - slot order 1110/0000001, 1101/1001111, 1011/0010010, 0111/0000110, then wraps to 1110.
3. Change D2 to 0000110 during the idx=2 slot -> seg unchanged for the rest of the frame; shown after the next frame_start.
4. Drop en for 5 cycles in the middle of the idx=1 slot -> an=1111, seg=1111111 from the next cycle; on en=1 the slot resumes with its remaining cycles intact.
5. Assert rst during the idx=3 slot -> next cycle blank and idx=0; the first enabled cycle after release reloads the snapshot and pulses frame_start.
6. [LEADING_ZERO_BLANK_EN] D4=D3=0000001, D2=1001111, D1=0000001 -> idx3 and idx2 slots stay an=1111; idx1 and idx0 are displayed. With all four digits zero, only the an=1110 slot is lit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit common-anode scan multiplexer.
// Segment vectors are [0:6] = a..g, active-low; anode vectors are active-low.
package seg7_pkg;

  typedef logic [0:6] seg_t;
  typedef logic [1:0] dig_idx_t;

  localparam seg_t        SEG_BLANK = 7'b1111111;
  localparam seg_t        SEG_ZERO  = 7'b0000001;
  localparam logic [3:0]  AN_OFF    = 4'b1111;

  // Active-low one-hot anode select: idx 0 drives an[0] (rightmost digit).
  function automatic logic [3:0] onehot_low(input dig_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Refresh prescaler: counts 0..DIV-1 while enabled, pulses tick on the last count.
// Holds its count while disabled; synchronous active-high reset.
module seg7_prescaler #(
  parameter int DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [$clog2(DIV)-1:0] cnt,
  output logic                   tick
);

  localparam int               CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes four 7-segment patterns onto a shared bus with per-frame
// snapshot and anode guard. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [0:6] D1,
  input  logic [0:6] D2,
  input  logic [0:6] D3,
  input  logic [0:6] D4,
  output logic [0:6] seg,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int               CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  dig_idx_t         idx;
  seg_t             snap [4];
  logic             load_pending;
  logic             load;
  logic             in_guard;
  logic             slot_blank;
  seg_t             seg_next;
  logic [3:0]       an_next;

  seg7_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .cnt  (cnt),
    .tick (tick)
  );

  // A new frame is latched either on the first enabled cycle after reset
  // or when the last digit slot ends, so a frame never mixes old and new D.
  assign load     = en && (load_pending || (tick && idx == 2'd3));
  assign in_guard = cnt < GUARD_C;

  // NOTE: the snapshot array is reset because it feeds seg directly; an
  // unreset memory would put X on the bus for the first enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      load_pending <= 1'b1;
      for (int i = 0; i < 4; i++) snap[i] <= SEG_BLANK;
    end else begin
      if (tick) idx <= idx + 1'b1;
      if (load) begin
        snap[0]      <= D1;
        snap[1]      <= D2;
        snap[2]      <= D3;
        snap[3]      <= D4;
        load_pending <= 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:1] mask;
  logic [3:1] mask_next;
  logic [3:0] mask_full;

  // A digit is suppressed only if it is zero and everything left of it is too.
  always_comb begin
    mask_next[3] = (D4 == SEG_ZERO);
    mask_next[2] = mask_next[3] && (D3 == SEG_ZERO);
    mask_next[1] = mask_next[2] && (D2 == SEG_ZERO);
  end

  always_ff @(posedge clk) begin
    if (rst)       mask <= '0;
    else if (load) mask <= mask_next;
  end

  assign mask_full  = {mask, 1'b0};
  assign slot_blank = mask_full[idx];
`else
  assign slot_blank = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path
  // through the ifs can leave it unassigned and infer a latch.
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = AN_OFF;
    if (en && !slot_blank) begin
      seg_next = snap[idx];
      if (!in_guard) an_next = onehot_low(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg         <= SEG_BLANK;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_next;
      an          <= an_next;
      frame_start <= load;
    end
  end

endmodule
